// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - fetch/decode/EX handshake and control bundle for ctrl_pipe
interface ctrl_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int ALUOP_W = 3
);
  logic               instr_valid;
  logic [DATA_W-1:0]  instr;
  logic               in_ready;
  logic               stall;
  logic [2:0]         flag_in;
  logic               flag_we;
  logic               ex_valid;
  logic [ALUOP_W-1:0] ex_aluop;
  logic               ex_reg_we;
  logic               ex_mem_en;
  logic               ex_mem_we;
  logic               ex_imm_sel;
  logic [1:0]         ex_wb_sel;
  logic               ex_hi;
  logic [1:0]         pc_sel;
  logic               flush;
  logic               exec_err;

  modport master (
    output instr_valid, instr, stall, flag_in, flag_we,
    input  in_ready, ex_valid, ex_aluop, ex_reg_we, ex_mem_en, ex_mem_we,
           ex_imm_sel, ex_wb_sel, ex_hi, pc_sel, flush, exec_err
  );

  modport slave (
    input  instr_valid, instr, stall, flag_in, flag_we,
    output in_ready, ex_valid, ex_aluop, ex_reg_we, ex_mem_en, ex_mem_we,
           ex_imm_sel, ex_wb_sel, ex_hi, pc_sel, flush, exec_err
  );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - decode, branch/jump resolution, flag hazard hold and EXEC sequencing
module ctrl_pipe #(
  parameter int DATA_W      = 16,
  parameter int ALUOP_W     = 3,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_pipe_if.slave bus
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_SLOT = 2'd3;

  localparam logic [2:0] DROP_INIT = 3'(FLUSH_SLOTS);

  logic [3:0] opc;
  logic [2:0] cond;
  logic       unused_instr;

  assign opc          = bus.instr[DATA_W-1 -: 4];
  assign cond         = bus.instr[DATA_W-5 -: 3];
  assign unused_instr = ^bus.instr[DATA_W-8:0];

  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_reg_we, dec_mem_en, dec_mem_we, dec_imm_sel, dec_hi;
  logic [1:0]         dec_wb_sel;
  logic               dec_setflag, dec_br, dec_jal, dec_jr, dec_exec;

  always_comb begin
    dec_aluop   = '0;
    dec_reg_we  = 1'b0;
    dec_mem_en  = 1'b0;
    dec_mem_we  = 1'b0;
    dec_imm_sel = 1'b0;
    dec_wb_sel  = 2'b00;
    dec_hi      = 1'b0;
    dec_setflag = 1'b0;
    dec_br      = 1'b0;
    dec_jal     = 1'b0;
    dec_jr      = 1'b0;
    dec_exec    = 1'b0;
    casez (opc)
      4'b00??: begin
        dec_aluop   = ALUOP_W'({1'b0, opc[1:0]});
        dec_reg_we  = 1'b1;
        dec_setflag = 1'b1;
      end
      4'b01??: begin
        dec_aluop   = ALUOP_W'({1'b1, opc[1:0]});
        dec_reg_we  = 1'b1;
        dec_imm_sel = 1'b1;
      end
      4'b1000: begin
        dec_reg_we  = 1'b1;
        dec_mem_en  = 1'b1;
        dec_imm_sel = 1'b1;
        dec_wb_sel  = 2'b01;
      end
      4'b1001: begin
        dec_mem_en  = 1'b1;
        dec_mem_we  = 1'b1;
        dec_imm_sel = 1'b1;
      end
      4'b101?: begin
        dec_reg_we = 1'b1;
        dec_wb_sel = 2'b11;
        dec_hi     = ~opc[0];
      end
      4'b1100: dec_br = 1'b1;
      4'b1101: begin
        dec_jal    = 1'b1;
        dec_reg_we = 1'b1;
        dec_wb_sel = 2'b10;
      end
      4'b1110: dec_jr   = 1'b1;
      default: dec_exec = 1'b1;
    endcase
  end

  function automatic logic br_taken(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    {n, v, z} = f;
    case (c)
      3'd0:    br_taken = z;
      3'd1:    br_taken = ~z;
      3'd2:    br_taken = ~z & ~n;
      3'd3:    br_taken = n;
      3'd4:    br_taken = z | ~n;
      3'd5:    br_taken = z | n;
      3'd6:    br_taken = v;
      default: br_taken = 1'b1;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [2:0]         flags_q, flags_d;
  logic [2:0]         drop_cnt_q, drop_cnt_d;
  logic               exec_pend_q, exec_pend_d;
  logic [2:0]         hold_cond_q, hold_cond_d;
  logic               ex_setflag_q, ex_setflag_d;
  logic               ex_valid_q, ex_valid_d;
  logic [ALUOP_W-1:0] ex_aluop_q, ex_aluop_d;
  logic               ex_reg_we_q, ex_reg_we_d;
  logic               ex_mem_en_q, ex_mem_en_d;
  logic               ex_mem_we_q, ex_mem_we_d;
  logic               ex_imm_sel_q, ex_imm_sel_d;
  logic [1:0]         ex_wb_sel_q, ex_wb_sel_d;
  logic               ex_hi_q, ex_hi_d;
  logic [1:0]         pc_sel_q, pc_sel_d;
  logic               flush_q, flush_d;
  logic               exec_err_q, exec_err_d;

  logic       accept, issue, use_dec, redirect;
  logic [1:0] redir_sel;

  assign accept = bus.instr_valid & (state_q != S_HOLD) & ~bus.stall;

  always_comb begin
    state_d     = state_q;
    flags_d     = bus.flag_we ? bus.flag_in : flags_q;
    drop_cnt_d  = drop_cnt_q;
    exec_pend_d = exec_pend_q;
    hold_cond_d = hold_cond_q;
    issue       = 1'b0;
    use_dec     = 1'b0;
    redirect    = 1'b0;
    redir_sel   = 2'b00;
    exec_err_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          // Same-cycle flag_we counts as already seen: branch uses the old flags.
          if (dec_br && ex_setflag_q && !bus.flag_we) begin
            state_d     = S_HOLD;
            hold_cond_d = cond;
          end else begin
            issue   = 1'b1;
            use_dec = 1'b1;
            if (dec_br && br_taken(cond, flags_q)) begin
              redirect  = 1'b1;
              redir_sel = 2'b01;
            end
            if (dec_jal) begin
              redirect  = 1'b1;
              redir_sel = 2'b01;
            end
            if (dec_jr || dec_exec) begin
              redirect  = 1'b1;
              redir_sel = 2'b10;
            end
            if (dec_exec) exec_pend_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // The held branch issues as a bubble-like control word and sees the fresh flags.
        if (bus.flag_we) begin
          issue   = 1'b1;
          state_d = S_RUN;
          if (br_taken(hold_cond_q, bus.flag_in)) begin
            redirect  = 1'b1;
            redir_sel = 2'b01;
          end
        end
      end
      S_DROP: begin
        if (accept) begin
          drop_cnt_d = drop_cnt_q - 3'd1;
          if (drop_cnt_q <= 3'd1) begin
            drop_cnt_d = 3'd0;
            state_d    = exec_pend_q ? S_SLOT : S_RUN;
          end
        end
      end
      default: begin
        if (accept) begin
          exec_pend_d = 1'b0;
          redirect    = 1'b1;
          redir_sel   = 2'b11;
          if (dec_br || dec_jal || dec_jr || dec_exec) begin
            exec_err_d = 1'b1;
          end else begin
            issue   = 1'b1;
            use_dec = 1'b1;
          end
        end
      end
    endcase
    if (redirect) begin
      state_d    = S_DROP;
      drop_cnt_d = DROP_INIT;
    end
  end

  always_comb begin
    ex_valid_d   = issue;
    ex_aluop_d   = use_dec ? dec_aluop : '0;
    ex_reg_we_d  = use_dec & dec_reg_we;
    ex_mem_en_d  = use_dec & dec_mem_en;
    ex_mem_we_d  = use_dec & dec_mem_we;
    ex_imm_sel_d = use_dec & dec_imm_sel;
    ex_wb_sel_d  = use_dec ? dec_wb_sel : 2'b00;
    ex_hi_d      = use_dec & dec_hi;
    ex_setflag_d = use_dec & dec_setflag;
    pc_sel_d     = redir_sel;
    flush_d      = redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      flags_q      <= 3'b000;
      drop_cnt_q   <= 3'd0;
      exec_pend_q  <= 1'b0;
      hold_cond_q  <= 3'd0;
      ex_setflag_q <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_aluop_q   <= '0;
      ex_reg_we_q  <= 1'b0;
      ex_mem_en_q  <= 1'b0;
      ex_mem_we_q  <= 1'b0;
      ex_imm_sel_q <= 1'b0;
      ex_wb_sel_q  <= 2'b00;
      ex_hi_q      <= 1'b0;
      pc_sel_q     <= 2'b00;
      flush_q      <= 1'b0;
      exec_err_q   <= 1'b0;
    end else if (!bus.stall) begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      drop_cnt_q   <= drop_cnt_d;
      exec_pend_q  <= exec_pend_d;
      hold_cond_q  <= hold_cond_d;
      ex_setflag_q <= ex_setflag_d;
      ex_valid_q   <= ex_valid_d;
      ex_aluop_q   <= ex_aluop_d;
      ex_reg_we_q  <= ex_reg_we_d;
      ex_mem_en_q  <= ex_mem_en_d;
      ex_mem_we_q  <= ex_mem_we_d;
      ex_imm_sel_q <= ex_imm_sel_d;
      ex_wb_sel_q  <= ex_wb_sel_d;
      ex_hi_q      <= ex_hi_d;
      pc_sel_q     <= pc_sel_d;
      flush_q      <= flush_d;
      exec_err_q   <= exec_err_d;
    end
  end

  assign bus.in_ready   = (state_q != S_HOLD);
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_aluop   = ex_aluop_q;
  assign bus.ex_reg_we  = ex_reg_we_q;
  assign bus.ex_mem_en  = ex_mem_en_q;
  assign bus.ex_mem_we  = ex_mem_we_q;
  assign bus.ex_imm_sel = ex_imm_sel_q;
  assign bus.ex_wb_sel  = ex_wb_sel_q;
  assign bus.ex_hi      = ex_hi_q;
  assign bus.pc_sel     = pc_sel_q;
  assign bus.flush      = flush_q;
  assign bus.exec_err   = exec_err_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - random plus scripted stimulus against a reference model, FLUSH_SLOTS 1 and 3
module tb_ctrl_pipe;
  localparam int DW = 16;
  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, stall, flag_we;
  logic [15:0] instr;
  logic [2:0]  flag_in;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.DATA_W(DW), .ALUOP_W(AW)) bus1 ();
  ctrl_pipe_if #(.DATA_W(DW), .ALUOP_W(AW)) bus3 ();

  assign bus1.instr_valid = instr_valid;
  assign bus1.instr       = instr;
  assign bus1.stall       = stall;
  assign bus1.flag_in     = flag_in;
  assign bus1.flag_we     = flag_we;
  assign bus3.instr_valid = instr_valid;
  assign bus3.instr       = instr;
  assign bus3.stall       = stall;
  assign bus3.flag_in     = flag_in;
  assign bus3.flag_we     = flag_we;

  ctrl_pipe #(.DATA_W(DW), .ALUOP_W(AW), .FLUSH_SLOTS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ctrl_pipe #(.DATA_W(DW), .ALUOP_W(AW), .FLUSH_SLOTS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [10:0] ex1, ex3;
  logic [4:0]  ctl1, ctl3;
  assign ex1  = {bus1.ex_valid, bus1.ex_aluop, bus1.ex_reg_we, bus1.ex_mem_en, bus1.ex_mem_we,
                 bus1.ex_imm_sel, bus1.ex_wb_sel, bus1.ex_hi};
  assign ex3  = {bus3.ex_valid, bus3.ex_aluop, bus3.ex_reg_we, bus3.ex_mem_en, bus3.ex_mem_we,
                 bus3.ex_imm_sel, bus3.ex_wb_sel, bus3.ex_hi};
  assign ctl1 = {bus1.in_ready, bus1.pc_sel, bus1.flush, bus1.exec_err};
  assign ctl3 = {bus3.in_ready, bus3.pc_sel, bus3.flush, bus3.exec_err};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: opcode table of {aluop, reg_we, mem_en, mem_we, imm_sel, wb_sel, hi}
  logic [9:0] dec_tab [16];

  function automatic logic [9:0] row(input int a, input bit rw, input bit me, input bit mw,
                                     input bit imm, input int wb, input bit hi);
    return {3'(a), rw, me, mw, imm, 2'(wb), hi};
  endfunction

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  int          slots [2] = '{1, 3};
  logic [2:0]  m_flags [2];
  bit          m_wait [2];
  logic [2:0]  m_wcond [2];
  int          m_drops [2];
  bit          m_slot_next [2];
  bit          m_slot [2];
  bit          m_prevf [2];
  logic [10:0] m_ex [2];
  logic [4:0]  m_ctl [2];

  task automatic model_step(input int k);
    logic [3:0] op;
    logic [2:0] cd;
    logic [9:0] fields;
    bit issue, err, fop;
    int sel;
    op = instr[15:12];
    cd = instr[11:9];
    if (rst) begin
      m_flags[k] = 3'b000; m_wait[k] = 0; m_drops[k] = 0;
      m_slot_next[k] = 0; m_slot[k] = 0; m_prevf[k] = 0;
      m_ex[k] = 11'd0; m_ctl[k] = 5'b10000;
      return;
    end
    if (stall) return;
    issue = 0; err = 0; fop = 0; fields = 10'd0; sel = -1;
    if (m_wait[k]) begin
      if (flag_we) begin
        issue = 1;
        m_wait[k] = 0;
        if (cond_true(m_wcond[k], flag_in)) sel = 1;
      end
    end else if (instr_valid) begin
      if (m_drops[k] > 0) begin
        m_drops[k]--;
        if (m_drops[k] == 0 && m_slot_next[k]) begin
          m_slot[k] = 1;
          m_slot_next[k] = 0;
        end
      end else if (m_slot[k]) begin
        m_slot[k] = 0;
        sel = 3;
        if (op >= 12) err = 1;
        else begin issue = 1; fields = dec_tab[op]; fop = (op < 4); end
      end else if (op == 12 && m_prevf[k] && !flag_we) begin
        m_wait[k] = 1;
        m_wcond[k] = cd;
      end else begin
        issue = 1; fields = dec_tab[op]; fop = (op < 4);
        case (op)
          4'd12: if (cond_true(cd, m_flags[k])) sel = 1;
          4'd13: sel = 1;
          4'd14: sel = 2;
          4'd15: begin sel = 2; m_slot_next[k] = 1; end
          default: ;
        endcase
      end
    end
    if (sel >= 0) m_drops[k] = slots[k];
    if (flag_we) m_flags[k] = flag_in;
    m_prevf[k] = fop;
    m_ex[k]  = issue ? {1'b1, fields} : 11'd0;
    m_ctl[k] = {!m_wait[k], (sel >= 0) ? 2'(sel) : 2'b00, sel >= 0, err};
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("ex_s1", 32'(ex1), 32'(m_ex[0]));
    check("ctl_s1", 32'(ctl1), 32'(m_ctl[0]));
    check("ex_s3", 32'(ex3), 32'(m_ex[1]));
    check("ctl_s3", 32'(ctl3), 32'(m_ctl[1]));
  endtask

  task automatic drv(input bit v, input logic [15:0] i, input bit s = 0, input bit fwe = 0,
                     input logic [2:0] fin = 3'b000, input bit r = 0);
    rst = r; instr_valid = v; instr = i; stall = s; flag_we = fwe; flag_in = fin;
    step();
  endtask

  function automatic logic [15:0] mk(input int op, input int c = 0);
    return {4'(op), 3'(c), 9'h0A5};
  endfunction

  task automatic settle();
    for (int j = 0; j < 8; j++) drv(1, mk(11));
  endtask

  initial begin
    logic [3:0] op;
    dec_tab[0]  = row(0, 1, 0, 0, 0, 0, 0);
    dec_tab[1]  = row(1, 1, 0, 0, 0, 0, 0);
    dec_tab[2]  = row(2, 1, 0, 0, 0, 0, 0);
    dec_tab[3]  = row(3, 1, 0, 0, 0, 0, 0);
    dec_tab[4]  = row(4, 1, 0, 0, 1, 0, 0);
    dec_tab[5]  = row(5, 1, 0, 0, 1, 0, 0);
    dec_tab[6]  = row(6, 1, 0, 0, 1, 0, 0);
    dec_tab[7]  = row(7, 1, 0, 0, 1, 0, 0);
    dec_tab[8]  = row(0, 1, 1, 0, 1, 1, 0);
    dec_tab[9]  = row(0, 0, 1, 1, 1, 0, 0);
    dec_tab[10] = row(0, 1, 0, 0, 0, 3, 1);
    dec_tab[11] = row(0, 1, 0, 0, 0, 3, 0);
    dec_tab[12] = 10'd0;
    dec_tab[13] = row(0, 1, 0, 0, 0, 2, 0);
    dec_tab[14] = 10'd0;
    dec_tab[15] = 10'd0;

    drv(0, 16'h0, 1, 0, 3'b000, 1);
    check("rst_ctl", 32'(ctl1), 32'h10);
    check("rst_ex", 32'(ex1), 32'h0);
    drv(1, mk(0));
    check("add_ex", 32'(ex1), 32'({1'b1, 3'b000, 4'b1000, 2'b00, 1'b0}));

    drv(1, mk(1));
    drv(1, mk(12, 0));
    check("hold_rdy", 32'(bus1.in_ready), 32'h0);
    drv(1, mk(0), 0, 1, 3'b001);
    check("br_take", 32'(ctl1), 32'({1'b1, 2'b01, 1'b1, 1'b0}));
    drv(1, mk(2));
    check("drop1", 32'(ex1), 32'h0);
    drv(1, mk(3));
    check("after_drop", 32'(ex1[10]), 32'h1);

    drv(0, 16'h0, 0, 1, 3'b100);
    drv(1, mk(12, 2));
    check("br_nt", 32'(ctl1), 32'h10);
    drv(1, mk(12, 5));
    check("br_t5", 32'(ctl1), 32'({1'b1, 2'b01, 1'b1, 1'b0}));

    settle();
    drv(1, mk(14));
    drv(1, mk(11));
    drv(0, mk(11));
    drv(1, mk(11));
    drv(0, mk(11));
    drv(1, mk(11));
    drv(1, mk(4));
    check("jr_4th", 32'(ex3), 32'({1'b1, 3'b100, 4'b1001, 2'b00, 1'b0}));

    settle();
    drv(1, mk(15));
    check("exec_pc", 32'(ctl1), 32'({1'b1, 2'b10, 1'b1, 1'b0}));
    drv(1, mk(11));
    drv(1, mk(8));
    check("slot_lw", 32'(ex1), 32'({1'b1, 3'b000, 4'b1101, 2'b01, 1'b0}));
    check("slot_ret", 32'(ctl1), 32'({1'b1, 2'b11, 1'b1, 1'b0}));
    settle();
    drv(1, mk(15));
    drv(1, mk(11));
    drv(1, mk(13));
    check("slot_jal_ex", 32'(ex1), 32'h0);
    check("slot_jal_err", 32'(ctl1), 32'({1'b1, 2'b11, 1'b1, 1'b1}));

    settle();
    drv(1, mk(14));
    for (int j = 0; j < 4; j++) begin
      drv(1, mk(0), 1);
      check("stall_hold", 32'(ctl1), 32'({1'b1, 2'b10, 1'b1, 1'b0}));
    end
    drv(1, mk(11));
    check("stall_drop", 32'(ex1), 32'h0);
    drv(1, mk(11));
    check("stall_after", 32'(ex1[10]), 32'h1);

    settle();
    drv(1, mk(15));
    drv(1, mk(11));
    drv(1, mk(8), 0, 0, 3'b000, 1);
    check("rst_slot_ctl", 32'(ctl1), 32'h10);
    check("rst_slot_ex", 32'(ex1), 32'h0);
    drv(1, mk(8));
    check("rst_slot_run", 32'(ctl1), 32'h10);

    for (int n = 0; n < 3000; n++) begin
      op = ($urandom_range(3) == 0) ? 4'd12 : 4'($urandom_range(15));
      drv($urandom_range(3) != 0, {op, 3'($urandom_range(7)), 9'($urandom)},
          $urandom_range(7) == 0, $urandom_range(3) == 0, 3'($urandom_range(7)),
          $urandom_range(199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
